mux_bus_arbiter: RTL
====================

MUX_BUS_ARBITER -- requirements
Module: mux_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4: number of requesters sharing one mux_bus; legal range 2..16.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16: maximum consecutive grant cycles per tenure when the timeout feature is compiled in; legal range >= 2.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port request, input, NUM_PORTS bits: bit i high means requester i wants the bus.
REQ-006 The block SHALL have port grant, output, NUM_PORTS bits: one-hot current owner, or all zero.
REQ-007 The block SHALL have port enable_port, output, log2(NUM_PORTS) bits: mux_bus select, equal to the owner index.
REQ-008 The block SHALL have port valid_enable, output, 1 bit: mux_bus output enable, high exactly when grant is non-zero.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-010 States SHALL be IDLE, GRANT and TURN, with all outputs registered.
REQ-011 In IDLE or TURN with request non-zero, the block SHALL grant the first set bit found by searching upward from rr_ptr with wrap-around, then enter GRANT; grant is visible one cycle after request is sampled.
REQ-012 In IDLE or TURN with request zero, the block SHALL go to IDLE with grant zero and valid_enable 0.
REQ-013 In GRANT, the grant SHALL hold while request[owner] stays high; requests from other ports SHALL NOT preempt it.
REQ-014 In GRANT, when request[owner] is sampled low, the block SHALL clear grant and valid_enable at that edge, set rr_ptr to (owner+1) mod NUM_PORTS, and enter TURN.
REQ-015 TURN SHALL last exactly one cycle with valid_enable 0, so there is at least one dead cycle between any two tenures.
REQ-016 enable_port SHALL retain the last owner index while valid_enable is 0; it changes only on a new grant.
REQ-017 grant SHALL never have more than one bit set; grant[enable_port] SHALL equal valid_enable in every cycle.
REQ-018 Simultaneous requests SHALL be served in round-robin order from rr_ptr; a port whose request drops before it is sampled in IDLE or TURN SHALL NOT be granted.

Reset
REQ-019 While reset_n is low, the block SHALL asynchronously set state=IDLE, grant=0, enable_port=0, valid_enable=0, timeout=0, rr_ptr=0 and hold_cnt=0.
REQ-020 Reset asserted mid-tenure SHALL drop the bus immediately without a TURN cycle.
REQ-021 After reset_n deasserts, the first arbitration SHALL occur at the first rising edge with reset_n high.

Configuration
REQ-022 With macro MUX_ARB_TIMEOUT_EN defined:
- hold_cnt SHALL count GRANT cycles from 1.
- When hold_cnt reaches MAX_HOLD with the owner still requesting, the block SHALL force the GRANT->TURN transition of REQ-014, pulse timeout for that one cycle, and clear hold_cnt.
- The preempted port SHALL be re-eligible from TURN onward, subject to rr_ptr.
REQ-023 Without MUX_ARB_TIMEOUT_EN, there SHALL be no hold_cnt logic; timeout SHALL be tied to 0, and tenures are unbounded.

Verification
REQ-024 Reset check: hold reset_n=0 with request=4'b1111 -> grant=0, enable_port=0, valid_enable=0; after release, grant=4'b0001 one cycle later.
REQ-025 Single requester: request=4'b0100 for 5 cycles, then 0 -> grant=4'b0100 and enable_port=2 for 5 cycles, then one TURN cycle with valid_enable=0, then IDLE.
REQ-026 Round-robin: request=4'b1111 held, each owner drops its request for one cycle after 2 granted cycles -> owner order 0,1,2,3,0, with exactly one dead cycle between tenures.
REQ-027 Wrap and skip: rr_ptr=3 (after a port-2 tenure), request=4'b0011 -> port 0 granted, then port 1.
REQ-028 Timeout, MUX_ARB_TIMEOUT_EN defined, MAX_HOLD=16: request=4'b0011 held, port 0 owner -> forced release after 16 grant cycles, timeout=1 for one cycle, port 1 granted after TURN. Without the macro: port 0 holds indefinitely and timeout stays 0.
REQ-029 Mid-tenure reset: reset_n pulsed low during a port-3 tenure -> valid_enable=0 asynchronously; rr_ptr=0 afterwards.
REQ-030 Integration: connect to mux_bus (WIDTH=8, NUM_PORTS=4) with data_in=32'h89ABCDEF -> bus data_out=8'hAB while port 2 owns the bus and 8'h00 during TURN cycles.

Source files
------------

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for a shared mux_bus: one owner at a time, one dead cycle between tenures.
// Define MUX_ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD grant cycles with a timeout pulse.
module mux_bus_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_PORTS-1:0]         request,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [$clog2(NUM_PORTS)-1:0] enable_port,
    output logic                         valid_enable,
    output logic                         timeout
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t               state_reg, state_next;
    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]     enable_port_reg, enable_port_next;
    logic                 valid_reg, valid_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic                 owner_req;
    logic                 hold_expired;
    logic [IDX_W-1:0]     next_ptr;

    // First requester at or above rr_ptr, wrapping past the top port.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            int cand;
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!pick_found && request[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
        end
    endgenerate

    assign owner_req = request[enable_port_reg];
    assign next_ptr  = (enable_port_reg == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                  : enable_port_reg + IDX_W'(1);

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        enable_port_next = enable_port_reg;
        valid_next       = valid_reg;
        rr_ptr_next      = rr_ptr_reg;
        case (state_reg)
            GRANT: begin
                if (!owner_req || hold_expired) begin
                    state_next  = TURN;
                    grant_next  = '0;
                    valid_next  = 1'b0;
                    rr_ptr_next = next_ptr;
                end
            end
            default: begin
                if (pick_found) begin
                    state_next       = GRANT;
                    grant_next       = pick_onehot;
                    enable_port_next = pick_idx;
                    valid_next       = 1'b1;
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                    valid_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            enable_port_reg <= '0;
            valid_reg       <= 1'b0;
            rr_ptr_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            enable_port_reg <= enable_port_next;
            valid_reg       <= valid_next;
            rr_ptr_reg      <= rr_ptr_next;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              timeout_reg;
    logic              start_grant;
    logic              forced;

    assign hold_expired = (hold_cnt_reg == HOLD_W'(MAX_HOLD));
    assign start_grant  = (state_reg != GRANT) && pick_found;
    assign forced       = (state_reg == GRANT) && owner_req && hold_expired;

    // hold_cnt reads 1 in the first grant cycle, so a tenure spans exactly MAX_HOLD cycles.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (start_grant) begin
            hold_cnt_next = HOLD_W'(1);
        end else if (state_reg == GRANT) begin
            if (!owner_req || hold_expired) hold_cnt_next = '0;
            else                            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= forced;
        end
    end

    assign timeout = timeout_reg;
`else
    assign hold_expired = (MAX_HOLD < 0);
    assign timeout      = 1'b0;
`endif

    assign grant        = grant_reg;
    assign enable_port  = enable_port_reg;
    assign valid_enable = valid_reg;

endmodule
